// File: rtl/demux_pkg.sv
// demux_pkg: shared constants, counter type and helpers for the 1-to-8 write demux
package demux_pkg;

   localparam int N_DEF = 8;
   localparam int S_DEF = 3;
   localparam int SLOTS = 8;
   localparam int CNT_W = 4;

   typedef logic [CNT_W-1:0] cnt_t;

   function automatic cnt_t count_ones(input logic [SLOTS-1:0] v);
      cnt_t c;
      c = '0;
      for (int i = 0; i < SLOTS; i++) c = c + cnt_t'(v[i]);
      return c;
   endfunction

endpackage

// File: rtl/demux_slot.sv
// demux_slot: one holding register with a valid flag, set on write and cleared on ack
module demux_slot
   import demux_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         wr,
   input  logic         ack,
   input  logic [N-1:0] d,
   output logic [N-1:0] q,
   output logic         valid
);

   // a write wins over an ack so a same-cycle refill keeps the slot full;
   // data is kept after an ack
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q     <= '0;
         valid <= 1'b0;
      end else begin
         if (wr) q <= d;
         valid <= wr | (valid & ~ack);
      end
   end

endmodule

// File: rtl/demux1x8_buf.sv
// demux1x8_buf: steers one word into one of eight buffered slots with valid/ack handshake
module demux1x8_buf
   import demux_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int S = S_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [S-1:0]     select,
   input  logic [N-1:0]     data_in,
   output logic [N-1:0]     out1,
   output logic [N-1:0]     out2,
   output logic [N-1:0]     out3,
   output logic [N-1:0]     out4,
   output logic [N-1:0]     out5,
   output logic [N-1:0]     out6,
   output logic [N-1:0]     out7,
   output logic [N-1:0]     out8,
   output logic [SLOTS-1:0] out_valid,
   input  logic [SLOTS-1:0] out_ack,
   output logic [CNT_W-1:0] busy_cnt
);

   logic             accept;
   logic [SLOTS-1:0] wr;
   logic [SLOTS-1:0] drain;
   logic             fill_empty;
   cnt_t             busy_next;
   logic [N-1:0]     q [SLOTS];

   // only the addressed slot can hold off the producer; an ack on it frees it this cycle
   assign in_ready = ~out_valid[select] | out_ack[select];
   assign accept   = in_valid & in_ready;

   // one-hot write strobe and the set of slots that really empty this cycle
   always_comb begin
      for (int i = 0; i < SLOTS; i++) wr[i] = accept && (select == S'(i));
      drain      = out_ack & out_valid & ~wr;
      fill_empty = accept & ~out_valid[select];
      busy_next  = busy_cnt + cnt_t'(fill_empty) - count_ones(drain);
   end

   genvar i;
   generate
      for (i = 0; i < SLOTS; i++) begin : g_slot
         demux_slot #(.N(N)) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .wr    (wr[i]),
            .ack   (out_ack[i]),
            .d     (data_in),
            .q     (q[i]),
            .valid (out_valid[i])
         );
      end
   endgenerate

   assign out1 = q[0];
   assign out2 = q[1];
   assign out3 = q[2];
   assign out4 = q[3];
   assign out5 = q[4];
   assign out6 = q[5];
   assign out7 = q[6];
   assign out8 = q[7];

   // occupancy counter tracks fills into empty slots minus real drains
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_cnt <= '0;
      else        busy_cnt <= busy_next;
   end

endmodule

// File: tb/tb_demux1x8_buf.sv
// tb_demux1x8_buf: directed and randomized checks of demux1x8_buf against a slot-array model
module tb_demux1x8_buf;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [2:0] select = '0;
   logic [7:0] data_in = '0;
   logic [7:0] out1, out2, out3, out4, out5, out6, out7, out8;
   logic [7:0] out_valid;
   logic [7:0] out_ack = '0;
   logic [3:0] busy_cnt;

   logic [7:0] outs [8];
   logic [7:0] mdata [8];
   logic [7:0] mvalid;
   logic       exp_ready;
   logic       obs_ready;
   int         tests = 0;
   int         fails = 0;

   demux1x8_buf dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .select    (select),
      .data_in   (data_in),
      .out1      (out1),
      .out2      (out2),
      .out3      (out3),
      .out4      (out4),
      .out5      (out5),
      .out6      (out6),
      .out7      (out7),
      .out8      (out8),
      .out_valid (out_valid),
      .out_ack   (out_ack),
      .busy_cnt  (busy_cnt)
   );

   always #5 clk = ~clk;

   assign outs[0] = out1;
   assign outs[1] = out2;
   assign outs[2] = out3;
   assign outs[3] = out4;
   assign outs[4] = out5;
   assign outs[5] = out6;
   assign outs[6] = out7;
   assign outs[7] = out8;

   task automatic model_clear();
      mvalid = '0;
      for (int i = 0; i < 8; i++) mdata[i] = '0;
   endtask

   // apply one cycle of inputs from a negedge, update the model at the edge, return at the next negedge
   task automatic drive(input logic v, input logic [2:0] s, input logic [7:0] d, input logic [7:0] a);
      logic acc;
      in_valid = v;
      select   = s;
      data_in  = d;
      out_ack  = a;
      #1;
      exp_ready = !mvalid[s] || a[s];
      obs_ready = in_ready;
      acc = v && exp_ready;
      @(posedge clk);
      mvalid = mvalid & ~a;
      if (acc) begin
         mvalid[s] = 1'b1;
         mdata[s]  = d;
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ack  = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      model_clear();
      for (int i = 0; i < 8; i++) begin
         tests++;
         if (outs[i] !== 8'h00) begin
            fails++;
            $display("FAIL reset_out%0d got %h want 00", i + 1, outs[i]);
         end
      end
      tests++;
      if (out_valid !== 8'h00 || busy_cnt !== 4'd0) begin
         fails++;
         $display("FAIL reset_state out_valid %h busy %0d want 00/0", out_valid, busy_cnt);
      end
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         select = 3'(i);
         #1;
         tests++;
         if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL idle_ready sel %0d got %b want 1", i, in_ready);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_single();
      drive(1'b1, 3'd5, 8'hA5, 8'h00);
      tests++;
      if (out6 !== 8'hA5 || out_valid !== 8'h20 || busy_cnt !== 4'd1) begin
         fails++;
         $display("FAIL single_write out6 %h valid %h busy %0d want a5/20/1", out6, out_valid, busy_cnt);
      end
      drive(1'b0, 3'd0, 8'h00, 8'h20);
      tests++;
      if (out6 !== 8'hA5 || out_valid !== 8'h00 || busy_cnt !== 4'd0) begin
         fails++;
         $display("FAIL single_ack out6 %h valid %h busy %0d want a5/00/0", out6, out_valid, busy_cnt);
      end
   endtask

   task automatic test_backpressure();
      drive(1'b1, 3'd2, 8'h11, 8'h00);
      drive(1'b1, 3'd2, 8'h22, 8'h00);
      tests++;
      if (obs_ready !== 1'b0 || out3 !== 8'h11) begin
         fails++;
         $display("FAIL bp_hold ready %b out3 %h want 0/11", obs_ready, out3);
      end
      drive(1'b1, 3'd2, 8'h22, 8'h04);
      tests++;
      if (obs_ready !== 1'b1 || out3 !== 8'h22 || out_valid[2] !== 1'b1 || busy_cnt !== 4'd1) begin
         fails++;
         $display("FAIL bp_refill ready %b out3 %h v2 %b busy %0d want 1/22/1/1", obs_ready, out3, out_valid[2], busy_cnt);
      end
   endtask

   task automatic test_nonblocking();
      drive(1'b0, 3'd0, 8'h00, 8'hFF);
      drive(1'b1, 3'd0, 8'h33, 8'h00);
      drive(1'b1, 3'd7, 8'h7E, 8'h00);
      tests++;
      if (obs_ready !== 1'b1 || out8 !== 8'h7E || busy_cnt !== 4'd2 || out_valid !== 8'h81) begin
         fails++;
         $display("FAIL nonblock ready %b out8 %h busy %0d valid %h want 1/7e/2/81", obs_ready, out8, busy_cnt, out_valid);
      end
   endtask

   task automatic test_fill_drain();
      drive(1'b0, 3'd0, 8'h00, 8'hFF);
      for (int i = 0; i < 8; i++) drive(1'b1, 3'(i), 8'h10 + 8'(i), 8'h00);
      tests++;
      if (busy_cnt !== 4'd8 || out_valid !== 8'hFF) begin
         fails++;
         $display("FAIL fill_all busy %0d valid %h want 8/ff", busy_cnt, out_valid);
      end
      for (int i = 0; i < 8; i++) begin
         tests++;
         if (outs[i] !== 8'h10 + 8'(i)) begin
            fails++;
            $display("FAIL fill_data slot %0d got %h want %h", i, outs[i], 8'h10 + 8'(i));
         end
      end
      drive(1'b0, 3'd0, 8'h00, 8'hFF);
      tests++;
      if (busy_cnt !== 4'd0 || out_valid !== 8'h00) begin
         fails++;
         $display("FAIL drain_all busy %0d valid %h want 0/00", busy_cnt, out_valid);
      end
      drive(1'b0, 3'd0, 8'h00, 8'hFF);
      tests++;
      if (busy_cnt !== 4'd0 || out_valid !== 8'h00 || out4 !== 8'h13) begin
         fails++;
         $display("FAIL ack_empty busy %0d valid %h out4 %h want 0/00/13", busy_cnt, out_valid, out4);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         drive(1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom & $urandom));
         tests++;
         if (obs_ready !== exp_ready) begin
            fails++;
            $display("FAIL rand_ready cyc %0d got %b want %b", n, obs_ready, exp_ready);
         end
         tests++;
         if (out_valid !== mvalid || busy_cnt !== 4'($countones(mvalid))) begin
            fails++;
            $display("FAIL rand_state cyc %0d valid %h busy %0d want %h/%0d", n, out_valid, busy_cnt, mvalid, $countones(mvalid));
         end
         for (int i = 0; i < 8; i++) begin
            tests++;
            if (outs[i] !== mdata[i]) begin
               fails++;
               $display("FAIL rand_data cyc %0d slot %0d got %h want %h", n, i, outs[i], mdata[i]);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      drive(1'b0, 3'd0, 8'h00, 8'hFF);
      drive(1'b1, 3'd1, 8'hC1, 8'h00);
      drive(1'b1, 3'd3, 8'hC3, 8'h00);
      drive(1'b1, 3'd6, 8'hC6, 8'h00);
      tests++;
      if (busy_cnt !== 4'd3) begin
         fails++;
         $display("FAIL areset_pre busy %0d want 3", busy_cnt);
      end
      in_valid = 1'b1;
      select   = 3'd4;
      data_in  = 8'h55;
      out_ack  = 8'h02;
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if (out_valid !== 8'h00 || busy_cnt !== 4'd0) begin
         fails++;
         $display("FAIL areset_state valid %h busy %0d want 00/0", out_valid, busy_cnt);
      end
      for (int i = 0; i < 8; i++) begin
         tests++;
         if (outs[i] !== 8'h00) begin
            fails++;
            $display("FAIL areset_out%0d got %h want 00", i + 1, outs[i]);
         end
      end
      model_clear();
      @(negedge clk);
      tests++;
      if (out_valid !== 8'h00 || out5 !== 8'h00) begin
         fails++;
         $display("FAIL areset_hold valid %h out5 %h want 00/00", out_valid, out5);
      end
      in_valid = 1'b0;
      out_ack  = '0;
      rst_n    = 1'b1;
      drive(1'b1, 3'd4, 8'h9D, 8'h00);
      tests++;
      if (out5 !== 8'h9D || out_valid !== 8'h10 || busy_cnt !== 4'd1) begin
         fails++;
         $display("FAIL areset_after out5 %h valid %h busy %0d want 9d/10/1", out5, out_valid, busy_cnt);
      end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_single();
      test_backpressure();
      test_nonblocking();
      test_fill_drain();
      test_random();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
